// File: rtl/cpu_controller.sv
// cpu_controller: instruction-sequencing controller for the 16-bit datapath.
// Fetches from unified memory, holds IR / PC / data-address registers,
// decodes, and drives every datapath strobe and select from a Moore FSM.
//
// Ports:
//   clk, reset_n         clock (rising edge), synchronous active-low reset
//   read_data[15:0]      memory read data (valid the cycle after a READ)
//   C[15:0]              datapath C bus; its low bits give the LDR/STR address
//   mem_cmd[1:0]         00 NONE, 01 READ, 10 WRITE
//   mem_addr[PC_WIDTH]   PC while fetching, data-address register otherwise
//   write/loada/loadb/loadc/loads/asel/bsel   datapath strobes and selects
//   vsel[1:0]            writeback source: 00 C, 01 PC, 10 sximm8, 11 m_data
//   readnum/writenum     register file indices
//   shift, ALUop         shifter op; ALU op (00 add, 01 sub, 10 and, 11 not B)
//   sximm8, sximm5       sign-extended IR[7:0] / IR[4:0]
//   PC                   program counter
//   halted               high while in HALT
module cpu_controller #(
  parameter int                  PC_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         read_data,
  input  logic [15:0]         C,
  output logic [1:0]          mem_cmd,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                write,
  output logic                loada,
  output logic                loadb,
  output logic                loadc,
  output logic                loads,
  output logic                asel,
  output logic                bsel,
  output logic [1:0]          vsel,
  output logic [2:0]          readnum,
  output logic [2:0]          writenum,
  output logic [1:0]          shift,
  output logic [1:0]          ALUop,
  output logic [15:0]         sximm8,
  output logic [15:0]         sximm5,
  output logic [PC_WIDTH-1:0] PC,
  output logic                halted
);

  localparam logic [1:0] CMD_NONE = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10;

  localparam logic [4:0] S_RST  = 5'd0,  S_IF1  = 5'd1,  S_IF2  = 5'd2,
                         S_UPC  = 5'd3,  S_DEC  = 5'd4,  S_WIMM = 5'd5,
                         S_GETA = 5'd6,  S_GETB = 5'd7,  S_EXEC = 5'd8,
                         S_WB   = 5'd9,  S_ADDR = 5'd10, S_LDA  = 5'd11,
                         S_MRD  = 5'd12, S_WBM  = 5'd13, S_STRC = 5'd14,
                         S_MWR  = 5'd15, S_HALT = 5'd16;

  logic [4:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] dad_q, dad_d;
  logic [15:0]         ir_q, ir_d;

  // Only the low PC_WIDTH bits of C form an address.
  logic unused_c;
  assign unused_c = ^C;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  logic is_alu, is_cmp, is_mvn, is_movsh, is_str, is_mem;
  assign is_alu   = (opc == 3'b101);
  assign is_cmp   = is_alu && (op == 2'b01);
  assign is_mvn   = is_alu && (op == 2'b11);
  assign is_movsh = (opc == 3'b110) && (op == 2'b00);
  assign is_str   = (opc == 3'b100);
  assign is_mem   = (opc == 3'b011) || is_str;

  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
  assign PC       = pc_q;
  assign mem_addr = (state_q == S_IF1 || state_q == S_IF2) ? pc_q : dad_q;

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dad_d   = dad_q;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      S_IF2:  begin state_d = S_UPC; ir_d = read_data; end
      S_UPC:  begin state_d = S_DEC; pc_d = pc_q + 1'b1; end  // wraps at max
      S_DEC: begin
        case (opc)
          3'b110:         state_d = (op == 2'b10) ? S_WIMM :
                                    (op == 2'b00) ? S_GETB : S_IF1;
          // MVN only needs B
          3'b101:         state_d = (op == 2'b11) ? S_GETB : S_GETA;
          3'b011, 3'b100: state_d = (op == 2'b00) ? S_GETA : S_IF1;
          3'b111:         state_d = S_HALT;
          default:        state_d = S_IF1;
        endcase
      end
      S_WIMM: state_d = S_IF1;
      S_GETA: state_d = is_mem ? S_ADDR : S_GETB;
      // STR reaches GET_B after the address is latched; B then carries Rd
      S_GETB: state_d = is_str ? S_STRC : S_EXEC;
      S_EXEC: state_d = is_cmp ? S_IF1 : S_WB;
      S_WB:   state_d = S_IF1;
      S_ADDR: state_d = S_LDA;
      S_LDA:  begin state_d = is_str ? S_GETB : S_MRD; dad_d = C[PC_WIDTH-1:0]; end
      S_MRD:  state_d = S_WBM;
      S_WBM:  state_d = S_IF1;
      S_STRC: state_d = S_MWR;
      S_MWR:  state_d = S_IF1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      dad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dad_q   <= dad_d;
    end
  end

  // Moore outputs: decoded from state and IR only
  always_comb begin
    mem_cmd  = CMD_NONE;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    halted   = 1'b0;
    case (state_q)
      S_IF1, S_IF2: mem_cmd = CMD_READ;
      S_WIMM: begin vsel = 2'b10; writenum = rn; write = 1'b1; end
      S_GETA: begin readnum = rn; loada = 1'b1; end
      S_GETB: begin readnum = is_str ? rd : rm; loadb = 1'b1; end
      S_EXEC: begin
        shift = sh;
        ALUop = is_alu ? op : 2'b00;
        asel  = is_movsh;             // MOV shift: 0 + B
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WB:   begin vsel = 2'b00; writenum = rd; write = 1'b1; end
      S_ADDR: begin bsel = 1'b1; loadc = 1'b1; end
      S_MRD:  mem_cmd = CMD_READ;
      // READ held so read_data stays valid through the writeback
      S_WBM:  begin mem_cmd = CMD_READ; vsel = 2'b11; writenum = rd; write = 1'b1; end
      S_STRC: begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:  mem_cmd = CMD_WRITE;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // is_mvn documents the decode path; kept visible for readability
  logic unused_mvn;
  assign unused_mvn = is_mvn;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   read_data, C;
  logic [1:0]    mem_cmd, vsel, shift, ALUop;
  logic [PW-1:0] mem_addr, PC;
  logic          write, loada, loadb, loadc, loads, asel, bsel, halted;
  logic [2:0]    readnum, writenum;
  logic [15:0]   sximm8, sximm5;

  always #5 clk = ~clk;

  cpu_controller #(.PC_WIDTH(PW), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset_n(reset_n), .read_data(read_data), .C(C),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .readnum(readnum), .writenum(writenum), .shift(shift),
    .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5), .PC(PC), .halted(halted)
  );

  logic [6:0] stb;
  assign stb = {write, loada, loadb, loadc, loads, asel, bsel};

  // ---------------- environment: memory + datapath ----------------
  logic [15:0] mem [512];
  logic [15:0] img [512];
  logic        img_load;
  logic [15:0] R [8];
  logic [15:0] A, B, dpC, rd_q;
  logic        Z;
  logic [15:0] ain, bin, alu, wdat;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'b00:   return v;
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  assign read_data = rd_q;
  assign C         = dpC;

  always_comb begin
    ain = asel ? 16'h0 : A;
    bin = bsel ? sximm5 : shf(B, shift);
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
    case (vsel)
      2'b00:   wdat = dpC;
      2'b01:   wdat = {{(16-PW){1'b0}}, PC};
      2'b10:   wdat = sximm8;
      default: wdat = read_data;
    endcase
  end

  always @(posedge clk) begin
    if (img_load) begin
      mem  <= img;
      rd_q <= '0;
      dpC  <= '0;
      A    <= '0;
      B    <= '0;
      Z    <= 1'b0;
      for (int i = 0; i < 8; i++) R[i] <= '0;
    end else begin
      if (mem_cmd == 2'b01) rd_q <= mem[mem_addr];
      if (mem_cmd == 2'b10) mem[mem_addr] <= dpC;
      if (write) R[writenum] <= wdat;
      if (loada) A <= R[readnum];
      if (loadb) B <= R[readnum];
      if (loadc) dpC <= alu;
      if (loads) Z <= (alu == 16'h0);
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [15:0] mmem [512];
  logic [15:0] mR [8];
  logic        mZ;
  logic [8:0]  mpc;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // load: replace memory image and clear architectural state in both worlds
  task automatic restart(input bit load);
    reset_n  = 1'b0;
    img_load = load;
    step();
    img_load = 1'b0;
    if (load) begin
      for (int i = 0; i < 512; i++) mmem[i] = img[i];
      for (int i = 0; i < 8; i++) mR[i] = '0;
      mZ = 1'b0;
    end
    step();
    chk("rst_cmd", mem_cmd, 0);
    chk("rst_stb", stb, 0);
    chk("rst_halt", halted, 0);
    chk("rst_pc", PC, 0);
    chk("rst_addr", mem_addr, 0);
    reset_n = 1'b1;
    step();
    mpc = 9'd0;
  endtask

  // Execute the instruction at mpc in the model and walk the DUT through it.
  task automatic run_instr(output bit hlt);
    logic [15:0] ir, s8, s5, bv, nv;
    logic [2:0]  opc, rn, rd, rm, wdst, bsrc;
    logic [1:0]  op, sh, wv, aop;
    logic [8:0]  ea, npc;
    int  cyc, e_lds, e_wc, e_rc, n_wr, n_lds, n_wc, n_rc, n_a, n_b, bad;
    bit  wr, uA, uB, nz;
    ir  = mmem[mpc];
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    s8  = {{8{ir[7]}}, ir[7:0]};
    s5  = {{11{ir[4]}}, ir[4:0]};
    npc = mpc + 9'd1;
    bv  = shf(mR[rm], sh);
    ea  = mR[rn][8:0] + s5[8:0];
    hlt = 1'b0; cyc = 4; wr = 1'b0; uA = 1'b0; uB = 1'b0;
    e_lds = 0; e_wc = 0; e_rc = 0; aop = 2'b00; wdst = 3'd0; wv = 2'b00; bsrc = rm;
    nv = 16'h0; nz = 1'b0;
    case (opc)
      3'b110: if (op == 2'b10) begin cyc = 5; wr = 1; wdst = rn; wv = 2'b10; nv = s8; end
              else if (op == 2'b00) begin cyc = 7; wr = 1; wdst = rd; uB = 1; nv = bv; end
      3'b101: begin
        uB = 1; aop = op; uA = (op != 2'b11); wdst = rd; wr = (op != 2'b01);
        cyc = (op == 2'b00 || op == 2'b10) ? 8 : 7;
        e_lds = (op == 2'b01) ? 1 : 0;
        nv = (op == 2'b00) ? mR[rn] + bv : (op == 2'b10) ? (mR[rn] & bv) : ~bv;
        nz = ((mR[rn] - bv) == 16'h0);
      end
      3'b011: if (op == 2'b00) begin cyc = 9; uA = 1; wr = 1; wdst = rd; wv = 2'b11; e_rc = 2; nv = mmem[ea]; end
      3'b100: if (op == 2'b00) begin cyc = 10; uA = 1; uB = 1; bsrc = rd; e_wc = 1; end
      3'b111: hlt = 1'b1;
      default: ;
    endcase
    n_wr = 0; n_lds = 0; n_wc = 0; n_rc = 0; n_a = 0; n_b = 0; bad = 0;
    for (int k = 0; k < cyc; k++) begin
      if (k == 0) begin
        chk("f_cmd", mem_cmd, 1); chk("f_addr", mem_addr, mpc); chk("f_pc", PC, mpc);
      end
      if (k == 1) begin chk("f2_cmd", mem_cmd, 1); chk("f2_addr", mem_addr, mpc); end
      if (k == 2) chk("upc_pc", PC, mpc);
      if (k == 3) begin
        chk("dec_pc", PC, npc); chk("sx8", sximm8, s8); chk("sx5", sximm5, s5);
        chk("dec_idle", {stb, mem_cmd}, 0);
      end
      if (write) begin n_wr++; if (writenum !== wdst || vsel !== wv) bad++; end
      if (loads) n_lds++;
      if (loada) begin n_a++; if (readnum !== rn) bad++; end
      if (loadb) begin n_b++; if (readnum !== bsrc) bad++; end
      if ((loadc || loads) && ALUop !== aop) bad++;
      if (mem_cmd == 2'b10) begin n_wc++; if (mem_addr !== ea) bad++; end
      if (k >= 4 && mem_cmd == 2'b01) begin n_rc++; if (mem_addr !== ea) bad++; end
      if (halted) bad++;
      step();
    end
    chk("n_write", n_wr, wr);
    chk("n_loads", n_lds, e_lds);
    chk("n_loada", n_a, uA);
    chk("n_loadb", n_b, uB);
    chk("n_memwr", n_wc, e_wc);
    chk("n_memrd", n_rc, e_rc);
    chk("sel_bad", bad, 0);
    if (e_wc != 0) mmem[ea] = mR[rd];
    if (wr) mR[wdst] = nv;
    if (e_lds != 0) mZ = nz;
    mpc = npc;
    if (hlt) begin
      for (int j = 0; j < 6; j++) begin
        chk("halted", halted, 1);
        chk("halt_pc", PC, npc);
        chk("halt_idle", {stb, mem_cmd}, 0);
        step();
      end
    end else begin
      if (wr) chk("reg", R[wdst], mR[wdst]);
      if (e_lds != 0) chk("zflag", Z, mZ);
      if (e_wc != 0) chk("memw", mem[ea], mmem[ea]);
    end
  endtask

  bit h;

  initial begin
    reset_n  = 1'b0;
    img_load = 1'b0;

    // Directed program
    for (int i = 0; i < 512; i++) img[i] = 16'h0000;
    img[0] = 16'hD105;  // MOV R1,#5
    img[1] = 16'hD223;  // MOV R2,#0x23
    img[2] = 16'hA2A1;  // ADD R5,R2,R1
    img[3] = 16'hA9E1;  // CMP R1,R1
    img[4] = 16'h6250;  // LDR R2,[R2,#-16] -> addr 0x13
    img[5] = 16'h81A2;  // STR R5,[R1,#2]   -> addr 7
    img[6] = 16'hE000;  // HALT
    img[9'h13] = 16'hBEEF;
    restart(1);
    h = 1'b0;
    for (int i = 0; i < 10 && !h; i++) run_instr(h);
    chk("d_halt_seen", h, 1);
    chk("d_r1", R[1], 16'h0005);
    chk("d_r5", R[5], 16'h0028);
    chk("d_r2", R[2], 16'hBEEF);
    chk("d_z", Z, 1);
    chk("d_mem7", mem[7], 16'h0028);

    // PC wrap: NOP sled with a MOV at the last address
    for (int i = 0; i < 512; i++) img[i] = 16'h0000;
    img[511] = 16'hD37F;  // MOV R3,#0x7F
    restart(1);
    for (int i = 0; i < 512; i++) run_instr(h);
    chk("wrap_pc", PC, 0);
    chk("wrap_r3", R[3], 16'h007F);

    // Random programs
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w;
      int cls;
      w   = 16'($urandom);
      cls = $urandom_range(0, 7);
      case (cls)
        0: w[15:11] = 5'b11010;
        1: w[15:11] = 5'b11000;
        2, 3, 4, 5: w[15:11] = {3'b101, 2'(cls - 2)};
        6: w[15:11] = 5'b01100;
        default: w[15:11] = 5'b10000;
      endcase
      if ($urandom_range(0, 15) == 0) w[15:13] = 3'b001;  // occasional NOP
      img[i] = w;
    end
    restart(1);
    for (int i = 0; i < 400; i++) begin
      run_instr(h);
      if (h) restart(0);
    end
    for (int i = 0; i < 8; i++) chk("rnd_reg", R[i], mR[i]);

    // Reset in the middle of a store
    for (int i = 0; i < 512; i++) img[i] = 16'h0000;
    img[0] = 16'h81A2;
    restart(1);
    for (int k = 0; k < 9; k++) step();
    chk("mwr_cmd", mem_cmd, 2);
    reset_n = 1'b0;
    step();
    chk("abort_cmd", mem_cmd, 0);
    chk("abort_pc", PC, 0);
    chk("abort_stb", stb, 0);
    reset_n = 1'b1;
    step();
    chk("after_rst_cmd", mem_cmd, 1);
    chk("after_rst_addr", mem_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
